// File: rtl/eh2_dec_trigger_csr.sv
// Per-thread debug-trigger CSR file: tselect/tdata1/tdata2 for four triggers
// per thread, chain resolution of incoming raw matches, hit tracking and the
// breakpoint / debug-halt requests toward the TLU.
//
// Handshake: csr_wr_valid_i is a single-cycle strobe taken at the rising edge;
// csr_rd_valid_i issued in cycle N returns csr_rdata_o with csr_rdata_valid_o
// high during cycle N+1 only (no back-pressure, one response per request).
//
// trigger_pkt_any_o[t][i] bit layout (38 bits):
//   [37] select  [36] match  [35] store  [34] load  [33] execute  [32] m
//   [31:0] tdata2
module eh2_dec_trigger_csr #(
    parameter int NUM_THREADS = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_THREADS-1:0]             dbg_mode_i,
    input  logic                               csr_wr_valid_i,
    input  logic                               csr_wr_tid_i,
    input  logic [11:0]                        csr_wr_addr_i,
    input  logic [31:0]                        csr_wr_data_i,
    input  logic                               csr_rd_valid_i,
    input  logic                               csr_rd_tid_i,
    input  logic [11:0]                        csr_rd_addr_i,
    output logic [31:0]                        csr_rdata_o,
    output logic                               csr_rdata_valid_o,
    input  logic                               match_valid_i,
    input  logic                               match_tid_i,
    input  logic [3:0]                         match_raw_i,
    output logic [NUM_THREADS-1:0][3:0][37:0]  trigger_pkt_any_o,
    output logic [3:0]                         trigger_fire_o,
    output logic [NUM_THREADS-1:0]             trigger_brkpt_o,
    output logic [NUM_THREADS-1:0]             trigger_halt_o
);

    localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
    localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
    localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;

    // Architectural state
    logic [NUM_THREADS-1:0][1:0]       tselect_q, tselect_d;
    logic [NUM_THREADS-1:0][3:0]       dmode_q, dmode_d;
    logic [NUM_THREADS-1:0][3:0]       hit_q, hit_d;
    logic [NUM_THREADS-1:0][3:0]       select_q, select_d;
    logic [NUM_THREADS-1:0][3:0]       action_q, action_d;
    logic [NUM_THREADS-1:0][3:0]       chain_q, chain_d;
    logic [NUM_THREADS-1:0][3:0]       match_q, match_d;
    logic [NUM_THREADS-1:0][3:0]       m_q, m_d;
    logic [NUM_THREADS-1:0][3:0]       execute_q, execute_d;
    logic [NUM_THREADS-1:0][3:0]       store_q, store_d;
    logic [NUM_THREADS-1:0][3:0]       load_q, load_d;
    logic [NUM_THREADS-1:0][3:0][31:0] tdata2_q, tdata2_d;
    logic [31:0]                       rdata_q, rdata_d;
    logic                              rvalid_q;

    // Combinational helpers
    logic [NUM_THREADS-1:0][3:0] fire_thr;
    logic [3:0]                  r_tmp;
    logic                        wr_tmp;
    logic                        tgt_tmp;
    logic                        dm_tmp;

    // Chain resolution and action decode; only the match_tid thread can fire
    always_comb begin
        fire_thr        = '0;
        r_tmp           = '0;
        trigger_fire_o  = '0;
        trigger_brkpt_o = '0;
        trigger_halt_o  = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            r_tmp = match_raw_i & {4{match_valid_i && (int'(match_tid_i) == t)}};
            for (int k = 0; k < 2; k++) begin
                if (chain_q[t][2*k]) begin
                    fire_thr[t][2*k]   = r_tmp[2*k] & r_tmp[2*k+1];
                    fire_thr[t][2*k+1] = r_tmp[2*k] & r_tmp[2*k+1];
                end else begin
                    fire_thr[t][2*k]   = r_tmp[2*k];
                    fire_thr[t][2*k+1] = r_tmp[2*k+1];
                end
            end
            trigger_fire_o     = trigger_fire_o | fire_thr[t];
            trigger_halt_o[t]  = |(fire_thr[t] & action_q[t] & dmode_q[t]);
            trigger_brkpt_o[t] = |(fire_thr[t] & ~(action_q[t] & dmode_q[t]));
        end
    end

    // Next-state for CSR writes, dmode locking and hit accumulation
    always_comb begin
        tselect_d = tselect_q;
        dmode_d   = dmode_q;
        hit_d     = hit_q;
        select_d  = select_q;
        action_d  = action_q;
        chain_d   = chain_q;
        match_d   = match_q;
        m_d       = m_q;
        execute_d = execute_q;
        store_d   = store_q;
        load_d    = load_q;
        tdata2_d  = tdata2_q;
        wr_tmp    = 1'b0;
        tgt_tmp   = 1'b0;
        dm_tmp    = 1'b0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            wr_tmp = csr_wr_valid_i && (int'(csr_wr_tid_i) == t);
            if (wr_tmp && (csr_wr_addr_i == ADDR_TSELECT)) begin
                tselect_d[t] = csr_wr_data_i[1:0];
            end
            for (int i = 0; i < 4; i++) begin
                hit_d[t][i] = hit_q[t][i] | fire_thr[t][i];
                // A trigger owned by debug mode cannot be touched from M-mode
                tgt_tmp = wr_tmp && (int'(tselect_q[t]) == i) &&
                          !(dmode_q[t][i] && !dbg_mode_i[t]);
                dm_tmp  = dbg_mode_i[t] ? csr_wr_data_i[27] : dmode_q[t][i];
                if (tgt_tmp && (csr_wr_addr_i == ADDR_TDATA1)) begin
                    dmode_d[t][i]   = dm_tmp;
                    hit_d[t][i]     = csr_wr_data_i[20] | fire_thr[t][i];
                    select_d[t][i]  = csr_wr_data_i[19];
                    action_d[t][i]  = (csr_wr_data_i[15:12] == 4'd1);
                    match_d[t][i]   = (csr_wr_data_i[10:7] == 4'd1);
                    m_d[t][i]       = csr_wr_data_i[6];
                    execute_d[t][i] = csr_wr_data_i[2];
                    store_d[t][i]   = csr_wr_data_i[1];
                    load_d[t][i]    = csr_wr_data_i[0];
                    // Chain only on even triggers, and only between equal dmodes
                    if (((i % 2) == 0) && (dmode_q[t][i|1] == dm_tmp)) begin
                        chain_d[t][i] = csr_wr_data_i[11];
                    end
                end
                if (tgt_tmp && (csr_wr_addr_i == ADDR_TDATA2)) begin
                    tdata2_d[t][i] = csr_wr_data_i;
                end
            end
        end
    end

    // Read mux over the registered state of the requesting thread
    always_comb begin
        rdata_d = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (int'(csr_rd_tid_i) == t) begin
                for (int i = 0; i < 4; i++) begin
                    if (int'(tselect_q[t]) == i) begin
                        case (csr_rd_addr_i)
                            ADDR_TSELECT: rdata_d = {30'b0, tselect_q[t]};
                            ADDR_TDATA1:  rdata_d = {4'd2, dmode_q[t][i], 6'd31,
                                                     hit_q[t][i], select_q[t][i], 1'b0, 5'b0,
                                                     action_q[t][i], chain_q[t][i], 3'b0,
                                                     match_q[t][i], m_q[t][i], 3'b0,
                                                     execute_q[t][i], store_q[t][i],
                                                     load_q[t][i]};
                            ADDR_TDATA2:  rdata_d = tdata2_q[t][i];
                            default:      rdata_d = '0;
                        endcase
                    end
                end
            end
        end
    end

    // Packets toward LSU/IFU match logic; m is gated so triggers sleep in debug mode
    always_comb begin
        trigger_pkt_any_o = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            for (int i = 0; i < 4; i++) begin
                trigger_pkt_any_o[t][i] = {select_q[t][i], match_q[t][i], store_q[t][i],
                                           load_q[t][i], execute_q[t][i],
                                           m_q[t][i] & ~dbg_mode_i[t], tdata2_q[t][i]};
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tselect_q <= '0;
            dmode_q   <= '0;
            hit_q     <= '0;
            select_q  <= '0;
            action_q  <= '0;
            chain_q   <= '0;
            match_q   <= '0;
            m_q       <= '0;
            execute_q <= '0;
            store_q   <= '0;
            load_q    <= '0;
            tdata2_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            tselect_q <= tselect_d;
            dmode_q   <= dmode_d;
            hit_q     <= hit_d;
            select_q  <= select_d;
            action_q  <= action_d;
            chain_q   <= chain_d;
            match_q   <= match_d;
            m_q       <= m_d;
            execute_q <= execute_d;
            store_q   <= store_d;
            load_q    <= load_d;
            tdata2_q  <= tdata2_d;
            rdata_q   <= csr_rd_valid_i ? rdata_d : 32'b0;
            rvalid_q  <= csr_rd_valid_i;
        end
    end

    assign csr_rdata_o       = rdata_q;
    assign csr_rdata_valid_o = rvalid_q;

endmodule
